// File: rtl/asmd_operand_sequencer_pkg.sv
// Shared definitions for the asmd operand sequencer: FSM state codes, default widths
// and a constant-evaluable clog2 used to size ports and counters.
package asmd_pkg;

    localparam int unsigned WORD_LENGTH_DEFAULT = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    function automatic int unsigned asmd_clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/asmd_operand_sequencer_fifo.sv
// Synchronous FIFO holding queued operand pairs; push is ignored when full, pop when empty.
module asmd_sync_fifo
    import asmd_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [width-1:0]           i_wdata,
    output logic [width-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [asmd_clog2(depth):0] o_count
);

    localparam int unsigned AW = asmd_clog2(depth);

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(depth));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage is not reset: pointers and count alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/asmd_operand_sequencer.sv
// Feeds queued operand pairs to asmd_multiplier one at a time and returns products in
// order on a valid/ready port; aborts and flags a sticky error if the multiplier hangs.
module asmd_operand_sequencer
    import asmd_pkg::*;
#(
    parameter int unsigned word_length    = WORD_LENGTH_DEFAULT,
    parameter int unsigned fifo_depth     = 4,
    parameter int unsigned timeout_cycles = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [word_length-1:0]          in_word0,
    input  logic [word_length-1:0]          in_word1,
    output logic                            mult_start,
    output logic [word_length-1:0]          mult_word0,
    output logic [word_length-1:0]          mult_word1,
    input  logic                            mult_ready,
    input  logic [2*word_length-1:0]        mult_product,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [2*word_length-1:0]        res_product,
    output logic                            busy,
    output logic                            error,
    output logic [asmd_clog2(fifo_depth):0] count
);

    localparam int unsigned TW = asmd_clog2(timeout_cycles + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(timeout_cycles - 1);

    logic [2:0]               r_state;
    logic [TW-1:0]            r_timer;
    logic                     r_start;
    logic [word_length-1:0]   r_word0;
    logic [word_length-1:0]   r_word1;
    logic                     r_res_valid;
    logic [2*word_length-1:0] r_res_product;
    logic                     r_error;

    logic [2*word_length-1:0] w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_timeout;

    assign w_pop     = (r_state == ST_IDLE) && !w_empty && mult_ready;
    assign w_timeout = (r_timer == TIMER_LAST);

    asmd_sync_fifo #(
        .width (2*word_length),
        .depth (fifo_depth)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_wdata ({in_word0, in_word1}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_start       <= 1'b0;
            r_word0       <= '0;
            r_word1       <= '0;
            r_res_valid   <= 1'b0;
            r_res_product <= '0;
            r_error       <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_word0, r_word1} <= w_head;
                        r_start            <= 1'b1;
                        r_state            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT_BUSY;
                end
                // Timeout takes priority over a completion seen on the same edge.
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                        if ((r_state == ST_WAIT_BUSY) && !mult_ready) begin
                            r_state <= ST_WAIT_DONE;
                        end else if ((r_state == ST_WAIT_DONE) && mult_ready) begin
                            r_res_product <= mult_product;
                            r_res_valid   <= 1'b1;
                            r_state       <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = !w_full;
    assign mult_start  = r_start;
    assign mult_word0  = r_word0;
    assign mult_word1  = r_word1;
    assign res_valid   = r_res_valid;
    assign res_product = r_res_product;
    assign busy        = (r_state != ST_IDLE);
    assign error       = r_error;

endmodule
